// File: rtl/stochastic_mult_serial.sv
// stochastic_mult_serial: CH-channel serial stochastic multiplier (AND/XNOR) with per-channel ones counting over a LEN-bit window
module stochastic_mult_serial #(
  parameter int CH = 4,
  parameter int LEN = 256,
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH-1:0]    a_bits,
  input  logic [CH-1:0]    b_bits,
  output logic [CH-1:0]    y_bits,
  output logic             y_valid,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*CW-1:0] y_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic mode_l;
  logic [CW-1:0] scnt;
  logic [CH-1:0] p;
  logic accept;
  assign p = mode_l ? ~(a_bits ^ b_bits) : (a_bits & b_bits);
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_l <= 1'b0;
      scnt <= '0;
      in_ready <= 1'b0;
      y_bits <= '0;
      y_valid <= 1'b0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      y_count <= '0;
    end else begin
      y_valid <= accept;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          mode_l <= mode;
          scnt <= '0;
          y_count <= '0;
          in_ready <= 1'b1;
          busy <= 1'b1;
        end
        RUN: if (accept) begin
          y_bits <= p;
          for (int k = 0; k < CH; k++)
            y_count[k*CW +: CW] <= y_count[k*CW +: CW] + CW'(p[k]);
          // the window closes on sample LEN; in_ready drops so no extra sample slips in
          if (scnt == CW'(LEN - 1)) begin
            state <= DONE;
            in_ready <= 1'b0;
            out_valid <= 1'b1;
          end else
            scnt <= scnt + 1'b1;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
